// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte-serial transmitter.
package byte_serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int timer_w(input int modulus);
        int w;
        w = $clog2(modulus);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/byte_serial_tx_if.sv
// Valid/ready word intake between the upstream shift register and the transmitter.
interface byte_serial_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/bit_timer.sv
// Per-bit down-counter: reloads on clear or terminal count, holds while disabled.
module bit_timer
    import byte_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc,
    output logic tc_next
);
    localparam int            W    = timer_w(CLKS_PER_BIT);
    localparam logic [W-1:0]  LOAD = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0]  ONE  = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= (clr || tc) ? LOAD : cnt - ONE;
    end

    assign tc = (cnt == '0);
    // Next enabled cycle will be terminal: lets the owner register a pulse for it.
    assign tc_next = (CLKS_PER_BIT == 1) ? 1'b1 : (!clr && cnt == ONE);

endmodule

// File: rtl/byte_serial_tx.sv
// Async serial framer: start, DATA_WIDTH data bits, optional even parity, stop.
// Parity is built only when BYTE_SERIAL_TX_PARITY_EN is defined.
module byte_serial_tx
    import byte_serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    byte_serial_tx_if.slave   up,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int            IW       = timer_w(DATA_WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic [IW-1:0]         idx;
    logic                  done_q;
    logic                  tc;
    logic                  tc_next;

    function automatic logic pick(input logic [DATA_WIDTH-1:0] w, input logic [IW-1:0] i);
        return (LSB_FIRST != 0) ? w[i] : w[IDX_LAST - i];
    endfunction

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (enable),
        .clr     (state == IDLE),
        .tc      (tc),
        .tc_next (tc_next)
    );

    assign up.in_ready = (state == IDLE) && enable;
    // done_q marks the stop bit's terminal cycle and survives stalls; it only shows while enabled.
    assign frame_done  = done_q && enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            hold   <= '0;
            tx_out <= LINE_IDLE;
            busy   <= 1'b0;
            done_q <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (up.in_valid) begin
                    hold   <= up.in_data;
                    state  <= START;
                    tx_out <= START_BIT;
                    busy   <= 1'b1;
                end
                START: if (tc) begin
                    state  <= DATA;
                    idx    <= '0;
                    tx_out <= pick(hold, '0);
                end
                DATA: if (tc) begin
                    if (idx == IDX_LAST) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
                        state  <= PARITY;
                        tx_out <= ^hold;
`else
                        state  <= STOP;
                        tx_out <= LINE_IDLE;
                        done_q <= tc_next;
`endif
                    end else begin
                        idx    <= idx + 1'b1;
                        tx_out <= pick(hold, idx + 1'b1);
                    end
                end
`ifdef BYTE_SERIAL_TX_PARITY_EN
                PARITY: if (tc) begin
                    state  <= STOP;
                    tx_out <= LINE_IDLE;
                    done_q <= tc_next;
                end
`endif
                STOP: if (tc) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    done_q <= tc_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_tx.sv
// Randomised self-checking bench; expected line waveforms come from a frame-list model.
module tb_byte_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef BYTE_SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = DW + 2 + PB;
    localparam int L     = NBITS * CPB;

    logic clk = 1'b0;
    logic rst, enable;
    logic tx_out, busy, frame_done;
    logic tx1, busy1, fd1;
    int   vectors = 0;
    int   errors  = 0;

    byte_serial_tx_if #(.DATA_WIDTH(DW)) bus ();
    byte_serial_tx_if #(.DATA_WIDTH(DW)) bus1 ();

    byte_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .LSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up(bus),
        .tx_out(tx_out), .busy(busy), .frame_done(frame_done));

    byte_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .LSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .up(bus1),
        .tx_out(tx1), .busy(busy1), .frame_done(fd1));

    always #5 clk = ~clk;

    typedef logic bitq_t[$];

    // Line level per clock for one frame: start, payload in chosen order, parity, stop.
    function automatic bitq_t build_frame(input logic [7:0] w, input int cpb, input bit lsb);
        bitq_t      q;
        logic       b;
        logic [7:0] s;
        for (int i = 0; i < NBITS; i++) begin
            if (i == 0) b = 1'b0;
            else if (i <= DW) begin
                s = lsb ? (w >> (i - 1)) : (w >> (DW - i));
                b = s[0];
            end else if (PB != 0 && i == DW + 1) b = ^w;
            else b = 1'b1;
            repeat (cpb) q.push_back(b);
        end
        return q;
    endfunction

    task automatic accept(input logic [7:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        repeat (2) begin
            @(negedge clk); vectors++;
            if ({tx_out, bus.in_ready, busy, frame_done, tx1, busy1} !== 6'b110010) begin
                errors++;
                $display("FAIL reset: tx/rdy/busy/fd/tx1/busy1 got %b want 110010",
                         {tx_out, bus.in_ready, busy, frame_done, tx1, busy1});
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; rst = 1'b0;
        @(negedge clk); vectors++;
        if ({tx_out, busy, bus.in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reset_no_capture: tx/busy/rdy got %b want 101", {tx_out, busy, bus.in_ready});
        end
    endtask

    // Cycle c shows position p = 1 + enabled edges since acceptance; stalls hold p.
    task automatic test_frame(input logic [7:0] w, input int stall_at, input int stall_len,
                              input bit rnd, input int exp_done);
        bitq_t q;
        int    p, c, done_c;
        logic  en;
        q = build_frame(w, CPB, 1'b1);
        vectors++;
        if ({bus.in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL pre_accept %h: rdy/busy got %b want 10", w, {bus.in_ready, busy});
        end
        accept(w);
        p = 1; c = 0; done_c = 0;
        while (p <= L && c < 2000) begin
            c++;
            en = rnd ? ($urandom_range(0, 3) != 0) : !(c >= stall_at && c < stall_at + stall_len);
            enable = en;
            @(negedge clk); vectors++;
            if ({tx_out, busy, bus.in_ready, frame_done} !== {q[p-1], 1'b1, 1'b0, (en && p == L)}) begin
                errors++;
                $display("FAIL frame %h cyc %0d pos %0d: tx/busy/rdy/fd got %b want %b", w, c, p,
                         {tx_out, busy, bus.in_ready, frame_done}, {q[p-1], 1'b1, 1'b0, (en && p == L)});
            end
            if (frame_done === 1'b1) done_c = c;
            @(posedge clk); #1;
            if (en) p++;
        end
        enable = 1'b1;
        @(negedge clk); vectors++;
        if ({tx_out, busy, bus.in_ready, frame_done} !== 4'b1010 || p <= L) begin
            errors++;
            $display("FAIL frame_end %h: tx/busy/rdy/fd got %b want 1010 (pos %0d of %0d)", w,
                     {tx_out, busy, bus.in_ready, frame_done}, p, L);
        end
        if (exp_done != 0) begin
            vectors++;
            if (done_c != exp_done) begin
                errors++;
                $display("FAIL done_cycle %h: got %0d want %0d", w, done_c, exp_done);
            end
        end
    endtask

    task automatic test_basic();
        test_frame(8'h1E, 0, 0, 1'b0, L);
    endtask

    task automatic test_stall();
        test_frame(8'hC3, 14, 3, 1'b0, L + 3);
    endtask

    task automatic test_random();
        repeat (5) test_frame(8'($urandom), 0, 0, 1'b1, 0);
    endtask

    task automatic test_rst_midframe();
        bitq_t q;
        q = build_frame(8'hFF, CPB, 1'b1);
        accept(8'hFF);
        for (int c = 1; c <= 18; c++) begin
            if (c == 18) rst = 1'b1;
            @(negedge clk); vectors++;
            if ({tx_out, busy} !== {q[c-1], 1'b1}) begin
                errors++;
                $display("FAIL rst_mid pre cyc %0d: tx/busy got %b want %b", c, {tx_out, busy}, {q[c-1], 1'b1});
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); vectors++;
            if ({tx_out, busy, bus.in_ready, frame_done} !== 4'b1010) begin
                errors++;
                $display("FAIL rst_mid post cyc %0d: tx/busy/rdy/fd got %b want 1010", c,
                         {tx_out, busy, bus.in_ready, frame_done});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        bitq_t q, qb;
        q  = build_frame(8'hA5, CPB, 1'b1);
        qb = build_frame(8'h3C, CPB, 1'b1);
        q.push_back(1'b1);
        foreach (qb[i]) q.push_back(qb[i]);
        bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_data = 8'h3C;
        for (int c = 1; c <= 2 * L + 1; c++) begin
            @(negedge clk); vectors++;
            if ({tx_out, busy, bus.in_ready, frame_done} !==
                {q[c-1], (c != L + 1), (c == L + 1), (c == L || c == 2 * L + 1)}) begin
                errors++;
                $display("FAIL b2b cyc %0d: tx/busy/rdy/fd got %b want %b", c,
                         {tx_out, busy, bus.in_ready, frame_done},
                         {q[c-1], (c != L + 1), (c == L + 1), (c == L || c == 2 * L + 1)});
            end
            @(posedge clk); #1;
            if (c == L + 1) bus.in_valid = 1'b0;
        end
        @(negedge clk); vectors++;
        if ({tx_out, busy, bus.in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_idle: tx/busy/rdy got %b want 101", {tx_out, busy, bus.in_ready});
        end
    endtask

    task automatic test_cpb1();
        bitq_t      q;
        logic [7:0] w;
        repeat (3) begin
            w = 8'($urandom);
            q = build_frame(w, 1, 1'b0);
            bus1.in_data = w; bus1.in_valid = 1'b1;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0; bus1.in_data = 8'($urandom);
            for (int c = 1; c <= NBITS; c++) begin
                @(negedge clk); vectors++;
                if ({tx1, busy1, fd1} !== {q[c-1], 1'b1, (c == NBITS)}) begin
                    errors++;
                    $display("FAIL cpb1 %h cyc %0d: tx/busy/fd got %b want %b", w, c,
                             {tx1, busy1, fd1}, {q[c-1], 1'b1, (c == NBITS)});
                end
                @(posedge clk); #1;
            end
            @(negedge clk); vectors++;
            if ({tx1, busy1, bus1.in_ready} !== 3'b101) begin
                errors++;
                $display("FAIL cpb1_idle %h: tx/busy/rdy got %b want 101", w, {tx1, busy1, bus1.in_ready});
            end
        end
    endtask

`ifdef BYTE_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        test_frame(8'h07, 0, 0, 1'b0, 44);
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0; bus.in_data  = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_rst_midframe();
        test_back_to_back();
`ifdef BYTE_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_cpb1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
